// File: rtl/pcie_tx_fc_gate.sv
// Transmit flow-control credit gate: per-VC FC init, credit limit tracking and TLP admission.
// Optional PCIE_FC_STALL_CNT_EN adds per-VC/per-type saturating stall counters on stall_cnt_o.
module pcie_tx_fc_gate #(
  parameter int unsigned CREDIT_DEPTH     = 12,
  parameter int unsigned NUM_VC           = 2,
  parameter int unsigned MAX_PAYLOAD_SIZE = 128,
  localparam int unsigned VcW             = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             link_active_i,
  input  logic [NUM_VC*CREDIT_DEPTH-1:0]   cl_ph_i,
  input  logic [NUM_VC*CREDIT_DEPTH-1:0]   cl_pd_i,
  input  logic [NUM_VC*CREDIT_DEPTH-1:0]   cl_nh_i,
  input  logic [NUM_VC*CREDIT_DEPTH-1:0]   cl_ch_i,
  input  logic [NUM_VC*CREDIT_DEPTH-1:0]   cl_cd_i,
  input  logic [NUM_VC*3-1:0]              cl_en_i,
  input  logic                             req_valid_i,
  input  logic [VcW-1:0]                   req_vc_i,
  input  logic [1:0]                       req_type_i,
  input  logic [10:0]                      req_len_dw_i,
  output logic                             req_ready_o,
  output logic                             req_err_o,
  output logic [NUM_VC*CREDIT_DEPTH-1:0]   cc_ph_o,
  output logic [NUM_VC*CREDIT_DEPTH-1:0]   cc_pd_o,
  output logic [NUM_VC*CREDIT_DEPTH-1:0]   cc_nh_o,
  output logic [NUM_VC*CREDIT_DEPTH-1:0]   cc_ch_o,
  output logic [NUM_VC*CREDIT_DEPTH-1:0]   cc_cd_o,
  output logic [NUM_VC-1:0]                vc_active_o
`ifdef PCIE_FC_STALL_CNT_EN
  ,
  output logic [NUM_VC*3*16-1:0]           stall_cnt_o
`endif
);

  typedef logic [CREDIT_DEPTH-1:0] cred_t;
  typedef enum logic {StInit, StActive} vc_state_e;

  localparam cred_t Half = cred_t'(1 << (CREDIT_DEPTH - 1));

  vc_state_e         r_state [NUM_VC];
  cred_t             r_cl_ph [NUM_VC];
  cred_t             r_cl_pd [NUM_VC];
  cred_t             r_cl_nh [NUM_VC];
  cred_t             r_cl_ch [NUM_VC];
  cred_t             r_cl_cd [NUM_VC];
  cred_t             r_cc_ph [NUM_VC];
  cred_t             r_cc_pd [NUM_VC];
  cred_t             r_cc_nh [NUM_VC];
  cred_t             r_cc_ch [NUM_VC];
  cred_t             r_cc_cd [NUM_VC];
  logic [NUM_VC-1:0] r_seen_p, r_seen_np, r_seen_cpl;
  logic [NUM_VC-1:0] r_inf_ph, r_inf_pd, r_inf_nh, r_inf_ch, r_inf_cd;
  logic              r_err;

  logic [8:0] w_need_d9;
  cred_t      w_need_d;
  logic       w_len_over, w_vc_bad, w_illegal;
  logic       w_sel_active, w_hdr_ok, w_dat_ok, w_ready;

  // Modular compare: a remaining-credit value in the upper half means the need overshoots.
  function automatic logic f_pass(input logic inf, input cred_t cl, input cred_t cc,
                                  input cred_t need);
    cred_t diff;
    diff = cl - (cc + need);
    return inf || (diff <= Half);
  endfunction

  assign w_need_d9  = 9'((12'(req_len_dw_i) + 12'd3) >> 2);
  assign w_need_d   = cred_t'(w_need_d9);
  assign w_len_over = (32'(req_len_dw_i) << 2) > MAX_PAYLOAD_SIZE;
  assign w_vc_bad   = 32'(req_vc_i) >= NUM_VC;
  assign w_illegal  = (req_type_i == 2'd3) | w_vc_bad | w_len_over |
                      ((req_type_i == 2'd1) & (req_len_dw_i > 11'd1));

  always_comb begin
    w_sel_active = 1'b0;
    w_hdr_ok     = 1'b0;
    w_dat_ok     = 1'b0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (32'(req_vc_i) == v) begin
        w_sel_active = (r_state[v] == StActive);
        case (req_type_i)
          2'd0: begin
            w_hdr_ok = f_pass(r_inf_ph[v], r_cl_ph[v], r_cc_ph[v], cred_t'(1));
            w_dat_ok = f_pass(r_inf_pd[v], r_cl_pd[v], r_cc_pd[v], w_need_d);
          end
          2'd1: begin
            w_hdr_ok = f_pass(r_inf_nh[v], r_cl_nh[v], r_cc_nh[v], cred_t'(1));
            w_dat_ok = 1'b1;
          end
          2'd2: begin
            w_hdr_ok = f_pass(r_inf_ch[v], r_cl_ch[v], r_cc_ch[v], cred_t'(1));
            w_dat_ok = f_pass(r_inf_cd[v], r_cl_cd[v], r_cc_cd[v], w_need_d);
          end
          default: ;
        endcase
      end
    end
  end

  assign w_ready     = req_valid_i & link_active_i & w_sel_active & w_hdr_ok & w_dat_ok &
                       ~w_illegal;
  assign req_ready_o = w_ready;
  assign req_err_o   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_seen_p   <= '0;
      r_seen_np  <= '0;
      r_seen_cpl <= '0;
      r_inf_ph   <= '0;
      r_inf_pd   <= '0;
      r_inf_nh   <= '0;
      r_inf_ch   <= '0;
      r_inf_cd   <= '0;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        r_state[v] <= StInit;
        r_cl_ph[v] <= '0;
        r_cl_pd[v] <= '0;
        r_cl_nh[v] <= '0;
        r_cl_ch[v] <= '0;
        r_cl_cd[v] <= '0;
        r_cc_ph[v] <= '0;
        r_cc_pd[v] <= '0;
        r_cc_nh[v] <= '0;
        r_cc_ch[v] <= '0;
        r_cc_cd[v] <= '0;
      end
    end else begin
      r_err <= req_valid_i & w_illegal;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (!link_active_i) begin
          r_state[v]    <= StInit;
          r_seen_p[v]   <= 1'b0;
          r_seen_np[v]  <= 1'b0;
          r_seen_cpl[v] <= 1'b0;
          r_inf_ph[v]   <= 1'b0;
          r_inf_pd[v]   <= 1'b0;
          r_inf_nh[v]   <= 1'b0;
          r_inf_ch[v]   <= 1'b0;
          r_inf_cd[v]   <= 1'b0;
          r_cl_ph[v]    <= '0;
          r_cl_pd[v]    <= '0;
          r_cl_nh[v]    <= '0;
          r_cl_ch[v]    <= '0;
          r_cl_cd[v]    <= '0;
          r_cc_ph[v]    <= '0;
          r_cc_pd[v]    <= '0;
          r_cc_nh[v]    <= '0;
          r_cc_ch[v]    <= '0;
          r_cc_cd[v]    <= '0;
        end else begin
          if (cl_en_i[3*v]) begin
            r_cl_ph[v]  <= cl_ph_i[v*CREDIT_DEPTH +: CREDIT_DEPTH];
            r_cl_pd[v]  <= cl_pd_i[v*CREDIT_DEPTH +: CREDIT_DEPTH];
            r_seen_p[v] <= 1'b1;
            if (r_state[v] == StInit) begin
              r_inf_ph[v] <= (cl_ph_i[v*CREDIT_DEPTH +: CREDIT_DEPTH] == '0);
              r_inf_pd[v] <= (cl_pd_i[v*CREDIT_DEPTH +: CREDIT_DEPTH] == '0);
            end
          end
          if (cl_en_i[3*v+1]) begin
            r_cl_nh[v]   <= cl_nh_i[v*CREDIT_DEPTH +: CREDIT_DEPTH];
            r_seen_np[v] <= 1'b1;
            if (r_state[v] == StInit) begin
              r_inf_nh[v] <= (cl_nh_i[v*CREDIT_DEPTH +: CREDIT_DEPTH] == '0);
            end
          end
          if (cl_en_i[3*v+2]) begin
            r_cl_ch[v]    <= cl_ch_i[v*CREDIT_DEPTH +: CREDIT_DEPTH];
            r_cl_cd[v]    <= cl_cd_i[v*CREDIT_DEPTH +: CREDIT_DEPTH];
            r_seen_cpl[v] <= 1'b1;
            if (r_state[v] == StInit) begin
              r_inf_ch[v] <= (cl_ch_i[v*CREDIT_DEPTH +: CREDIT_DEPTH] == '0);
              r_inf_cd[v] <= (cl_cd_i[v*CREDIT_DEPTH +: CREDIT_DEPTH] == '0);
            end
          end
          if ((r_state[v] == StInit) && (r_seen_p[v] | cl_en_i[3*v]) &&
              (r_seen_np[v] | cl_en_i[3*v+1]) && (r_seen_cpl[v] | cl_en_i[3*v+2])) begin
            r_state[v] <= StActive;
          end
          // Consumption is counted even for infinite fields.
          if (w_ready && (32'(req_vc_i) == v)) begin
            case (req_type_i)
              2'd0: begin
                r_cc_ph[v] <= r_cc_ph[v] + cred_t'(1);
                r_cc_pd[v] <= r_cc_pd[v] + w_need_d;
              end
              2'd1: r_cc_nh[v] <= r_cc_nh[v] + cred_t'(1);
              2'd2: begin
                r_cc_ch[v] <= r_cc_ch[v] + cred_t'(1);
                r_cc_cd[v] <= r_cc_cd[v] + w_need_d;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    cc_ph_o     = '0;
    cc_pd_o     = '0;
    cc_nh_o     = '0;
    cc_ch_o     = '0;
    cc_cd_o     = '0;
    vc_active_o = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      cc_ph_o[v*CREDIT_DEPTH +: CREDIT_DEPTH] = r_cc_ph[v];
      cc_pd_o[v*CREDIT_DEPTH +: CREDIT_DEPTH] = r_cc_pd[v];
      cc_nh_o[v*CREDIT_DEPTH +: CREDIT_DEPTH] = r_cc_nh[v];
      cc_ch_o[v*CREDIT_DEPTH +: CREDIT_DEPTH] = r_cc_ch[v];
      cc_cd_o[v*CREDIT_DEPTH +: CREDIT_DEPTH] = r_cc_cd[v];
      vc_active_o[v] = (r_state[v] == StActive);
    end
  end

`ifdef PCIE_FC_STALL_CNT_EN
  logic [15:0] r_stall [NUM_VC*3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VC*3; i++) r_stall[i] <= '0;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        for (int unsigned t = 0; t < 3; t++) begin
          if (!link_active_i) begin
            r_stall[v*3+t] <= '0;
          end else if (req_valid_i && !w_illegal && w_sel_active && !w_ready &&
                       (32'(req_vc_i) == v) && (32'(req_type_i) == t) &&
                       (r_stall[v*3+t] != 16'hFFFF)) begin
            r_stall[v*3+t] <= r_stall[v*3+t] + 16'd1;
          end
        end
      end
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int unsigned i = 0; i < NUM_VC*3; i++) stall_cnt_o[i*16 +: 16] = r_stall[i];
  end
`endif

endmodule

// File: tb/tb_pcie_tx_fc_gate.sv
// Directed self-checking bench for pcie_tx_fc_gate (CREDIT_DEPTH=12, NUM_VC=2, MPS=128).
module tb_pcie_tx_fc_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_active_i;
  logic [23:0] cl_ph_i, cl_pd_i, cl_nh_i, cl_ch_i, cl_cd_i;
  logic [5:0]  cl_en_i;
  logic        req_valid_i;
  logic [0:0]  req_vc_i;
  logic [1:0]  req_type_i;
  logic [10:0] req_len_dw_i;
  logic        req_ready_o, req_err_o;
  logic [23:0] cc_ph_o, cc_pd_o, cc_nh_o, cc_ch_o, cc_cd_o;
  logic [1:0]  vc_active_o;
`ifdef PCIE_FC_STALL_CNT_EN
  logic [95:0] stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int bad;

  always #5 clk = ~clk;

  pcie_tx_fc_gate #(
    .CREDIT_DEPTH     (12),
    .NUM_VC           (2),
    .MAX_PAYLOAD_SIZE (128)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .link_active_i (link_active_i),
    .cl_ph_i       (cl_ph_i),
    .cl_pd_i       (cl_pd_i),
    .cl_nh_i       (cl_nh_i),
    .cl_ch_i       (cl_ch_i),
    .cl_cd_i       (cl_cd_i),
    .cl_en_i       (cl_en_i),
    .req_valid_i   (req_valid_i),
    .req_vc_i      (req_vc_i),
    .req_type_i    (req_type_i),
    .req_len_dw_i  (req_len_dw_i),
    .req_ready_o   (req_ready_o),
    .req_err_o     (req_err_o),
    .cc_ph_o       (cc_ph_o),
    .cc_pd_o       (cc_pd_o),
    .cc_nh_o       (cc_nh_o),
    .cc_ch_o       (cc_ch_o),
    .cc_cd_o       (cc_cd_o),
    .vc_active_o   (vc_active_o)
`ifdef PCIE_FC_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int v, input int k, input logic [11:0] h, input logic [11:0] d);
    case (k)
      0: begin cl_ph_i[v*12 +: 12] = h; cl_pd_i[v*12 +: 12] = d; end
      1: cl_nh_i[v*12 +: 12] = h;
      default: begin cl_ch_i[v*12 +: 12] = h; cl_cd_i[v*12 +: 12] = d; end
    endcase
    cl_en_i = '0;
    cl_en_i[v*3+k] = 1'b1;
    step();
    cl_en_i = '0;
  endtask

  task automatic req(input int v, input int t, input int len);
    req_valid_i  = 1'b1;
    req_vc_i     = v[0];
    req_type_i   = t[1:0];
    req_len_dw_i = len[10:0];
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; link_active_i = 1'b0;
    cl_ph_i = '0; cl_pd_i = '0; cl_nh_i = '0; cl_ch_i = '0; cl_cd_i = '0; cl_en_i = '0;
    req_valid_i = 1'b0; req_vc_i = '0; req_type_i = '0; req_len_dw_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_err", req_err_o, 0);
    chk("rst_active", vc_active_o, 0);
    chk("rst_cc_ph", cc_ph_o, 0);
    chk("rst_cc_cd", cc_cd_o, 0);
    rst = 1'b0; link_active_i = 1'b1;
    step();

    // FC init on VC0 and a first posted write
    strobe(0, 0, 12'd4, 12'd16);
    strobe(0, 1, 12'd2, 12'd0);
    chk("init_not_yet", vc_active_o, 2'b00);
    strobe(0, 2, 12'd0, 12'd0);
    chk("init_active", vc_active_o, 2'b01);
    req(0, 0, 8);
    chk("p_ready", req_ready_o, 1);
    step();
    req_valid_i = 1'b0;
    chk("p_cc_ph", cc_ph_o[11:0], 1);
    chk("p_cc_pd", cc_pd_o[11:0], 2);
    chk("p_no_err", req_err_o, 0);

    // Exhaust PH=4, then raise the limit under a held request
    for (int i = 0; i < 3; i++) begin
      req(0, 0, 0);
      chk("exh_grant", req_ready_o, 1);
      step();
    end
    req(0, 0, 0);
    chk("exh_5th_stall", req_ready_o, 0);
    chk("exh_cc_ph", cc_ph_o[11:0], 4);
    step();
    cl_ph_i[11:0] = 12'd5; cl_en_i = 6'b000001;
    #1;
    chk("exh_strobe_cycle", req_ready_o, 0);
    step();
    cl_en_i = '0;
    #1;
    chk("exh_after_strobe", req_ready_o, 1);
    step();
    req_valid_i = 1'b0;
    chk("exh_cc_ph5", cc_ph_o[11:0], 5);

    // Non-posted header consumption
    req(0, 1, 1);
    chk("np_ready", req_ready_o, 1);
    step();
    req_valid_i = 1'b0;
    chk("np_cc_nh", cc_nh_o[11:0], 1);
    chk("np_cc_pd_same", cc_pd_o[11:0], 2);

    // Infinite completion credits
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      req(0, 2, 32);
      if (req_ready_o !== 1'b1) bad++;
      step();
    end
    req_valid_i = 1'b0;
    chk("inf_ready_all", bad, 0);
    chk("inf_cc_cd", cc_cd_o[11:0], 3136);
    chk("inf_cc_ch", cc_ch_o[11:0], 904);

    // Illegal requests
    req(0, 3, 0);
    chk("ill_type_ready", req_ready_o, 0);
    step();
    req_valid_i = 1'b0;
    chk("ill_type_err", req_err_o, 1);
    step();
    chk("ill_err_pulse_end", req_err_o, 0);
    req(0, 1, 2);
    chk("ill_np_len_ready", req_ready_o, 0);
    step();
    req_valid_i = 1'b0;
    chk("ill_np_len_err", req_err_o, 1);
    req(0, 0, 33);
    chk("ill_mps_ready", req_ready_o, 0);
    step();
    req_valid_i = 1'b0;
    chk("ill_mps_err", req_err_o, 1);

    // Wrap-around on VC1
    strobe(1, 0, 12'd2048, 12'd2048);
    strobe(1, 1, 12'd2, 12'd0);
    strobe(1, 2, 12'd1, 12'd1);
    chk("vc1_active", vc_active_o, 2'b11);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      req(1, 0, 32);
      if (req_ready_o !== 1'b1) bad++;
      step();
    end
    req_valid_i = 1'b0;
    chk("wrap_fill1", bad, 0);
    chk("wrap_cc_pd_2048", cc_pd_o[23:12], 2048);
    strobe(1, 0, 12'd2048, 12'd4094);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      req(1, 0, 32);
      if (req_ready_o !== 1'b1) bad++;
      step();
    end
    req(1, 0, 24);
    if (req_ready_o !== 1'b1) bad++;
    step();
    req_valid_i = 1'b0;
    chk("wrap_fill2", bad, 0);
    chk("wrap_cc_pd_4094", cc_pd_o[23:12], 4094);
    strobe(1, 0, 12'd2048, 12'd2);
    req(1, 0, 16);
    chk("wrap_grant", req_ready_o, 1);
    step();
    req_valid_i = 1'b0;
    chk("wrap_cc_pd_2", cc_pd_o[23:12], 2);
    chk("wrap_cc_ph", cc_ph_o[23:12], 513);
    req(1, 0, 4);
    chk("wrap_stall", req_ready_o, 0);

    // Link drop with an otherwise grantable request
    req(1, 0, 0);
    chk("drop_pre_ready", req_ready_o, 1);
    link_active_i = 1'b0;
    #1;
    chk("drop_same_cycle", req_ready_o, 0);
    step();
    req_valid_i = 1'b0;
    chk("drop_active", vc_active_o, 0);
    chk("drop_cc_ph", cc_ph_o, 0);
    chk("drop_cc_pd", cc_pd_o, 0);
    chk("drop_cc_nh", cc_nh_o, 0);
    chk("drop_cc_ch", cc_ch_o, 0);
    chk("drop_cc_cd", cc_cd_o, 0);
    link_active_i = 1'b1;
    step();

    // Simultaneous strobe and request on VC1
    strobe(1, 0, 12'd3, 12'd16);
    strobe(1, 1, 12'd2, 12'd0);
    strobe(1, 2, 12'd1, 12'd1);
    req(0, 0, 0);
    chk("vc0_still_init", req_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      req(1, 0, 0);
      chk("sim_grant", req_ready_o, 1);
      step();
    end
    req(1, 0, 0);
    chk("sim_exhausted", req_ready_o, 0);
    chk("sim_cc_ph3", cc_ph_o[23:12], 3);
    step();
    cl_ph_i[23:12] = 12'd4; cl_en_i = 6'b001000;
    #1;
    chk("sim_same_cycle", req_ready_o, 0);
    step();
    cl_en_i = '0;
    #1;
    chk("sim_next_cycle", req_ready_o, 1);
    step();
    req_valid_i = 1'b0;
    chk("sim_cc_ph4", cc_ph_o[23:12], 4);

    // Asynchronous reset clears state without a clock edge
    rst = 1'b1;
    #1;
    chk("async_rst_cc", cc_ph_o, 0);
    chk("async_rst_active", vc_active_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_tx_fc_gate.md
# pcie_tx_fc_gate

Transmit-side flow-control credit gate placed between the transaction layer's TLP scheduler and the data-link layer.
- Tracks consumed credits against the link partner's advertised limits for Posted, Non-Posted and Completion traffic, for each of `NUM_VC` virtual channels.
- Admits a TLP only when the required header and data credits are available.
- Generalises the single-VC credit wiring of the current link top with:
  - a configurable VC count,
  - an FC-init state machine,
  - infinite-credit handling,
  - modular limit comparison.

## Interface
Parameters:
- `CREDIT_DEPTH`, 12: width of every credit counter and limit, modulo 2^CREDIT_DEPTH.
- `NUM_VC`, 2: number of virtual channels, 1–8.
- `MAX_PAYLOAD_SIZE`, 128: bytes. Any request with a longer payload is rejected.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. Asynchronous, active-high.
- `link_active_i`  in  1: DLL reports link up.
- `cl_ph_i`, `cl_pd_i`, `cl_nh_i`, `cl_ch_i`, `cl_cd_i`  in  NUM_VC*CREDIT_DEPTH each: advertised limits. VC v occupies slice [v*CREDIT_DEPTH +: CREDIT_DEPTH].
- `cl_en_i`  in  NUM_VC*3: limit-valid strobes. Bit 3v is P, bit 3v+1 is NP, bit 3v+2 is CPL.
- `req_valid_i`  in  1: a TLP is requesting transmission.
- `req_vc_i`  in  $clog2(NUM_VC) (minimum 1): VC of the request.
- `req_type_i`  in  2: 0 = P, 1 = NP, 2 = CPL, 3 = illegal.
- `req_len_dw_i`  in  11: payload length in DW. 0 means no payload.
- `req_ready_o`  out  1: credits are available; the TLP may be sent.
- `req_err_o`  out  1: one-cycle pulse on an illegal request.
- `cc_ph_o`, `cc_pd_o`, `cc_nh_o`, `cc_ch_o`, `cc_cd_o`  out  NUM_VC*CREDIT_DEPTH each: consumed-credit counters.
- `vc_active_o`  out  NUM_VC: the VC has completed FC init.

## Operation
Per-VC state machine:
- States are `INIT` and `ACTIVE`.
- `INIT` → `ACTIVE` once P, NP and CPL limits have each been strobed at least once since entering `INIT`. Three sticky flags track this.
- Any state → `INIT` when `link_active_i` = 0. In that case the VC clears all of its counters, limits, sticky flags and infinite flags.

Limit capture:
- On a `cl_en_i` bit, the corresponding header and data limits are registered. Updates are accepted in both `INIT` and `ACTIVE`.
- While in `INIT`, a captured value of 0 sets a per-field infinite flag.
- While in `ACTIVE`, the infinite flags are frozen: a later 0 write updates the limit register but does not clear the flag.

Credit requirement:
- Header credits: 1.
- Data credits: ceil(req_len_dw_i / 4), i.e. (len + 3) >> 2, computed in 9 bits.
- NP requests require 0 data credits and do not track NP data.

Availability test, per field:
- The field passes if its infinite flag is set, or if (CL − (CC + need)) mod 2^CREDIT_DEPTH ≤ 2^(CREDIT_DEPTH−1).

`req_ready_o` is 1 only when all of the following hold:
- `req_valid_i` = 1;
- the addressed VC is `ACTIVE`;
- the header and data fields of the requested type both pass;
- the request is legal.

A request is illegal when any of the following holds:
- type = 3;
- `req_vc_i` ≥ NUM_VC;
- length × 4 > MAX_PAYLOAD_SIZE;
- NP with length > 1.

On an illegal request, `req_ready_o` = 0 and `req_err_o` pulses the following cycle.

Consumption:
- On valid && ready, CC[type] += need, wrapping modulo 2^CREDIT_DEPTH.
- CC is incremented even when the field is infinite.

## Timing
- All outputs reset to 0.
- `req_ready_o` is combinational from registered state and the current request. Zero-cycle handshake; back-to-back grants are allowed every cycle.
- CC updates take effect on the clock edge after the grant. The next cycle's ready check uses the updated CC.
- A limit strobe and a grant in the same cycle:
  - both commit;
  - that cycle's ready uses the old limit;
  - the new limit affects the next cycle.
- The `INIT` → `ACTIVE` transition is registered. `vc_active_o` and ready eligibility begin the cycle after the third strobe.
- When `link_active_i` falls, ready drops combinationally in the same cycle. Counters and state clear on the next edge.
- Asserting `rst` mid-grant discards the grant: counters go to 0 asynchronously.
- `req_valid_i` must be held until ready. A request is granted exactly once, in the cycle where valid && ready.

## Configuration
`PCIE_FC_STALL_CNT_EN`:
- Defined: adds output `stall_cnt_o` [NUM_VC*3*16]. Each entry is a 16-bit saturating counter per VC and type, counting cycles in which a legal request to an `ACTIVE` VC was valid && !ready. Counters clear on `rst` or on link down, and saturate at 16'hFFFF.
- Undefined: the port and the counters are absent. All other behaviour is identical.

## Test plan
- Init and basic P write:
  - Stimulus: CREDIT_DEPTH=12, VC0. Strobe P (PH=4, PD=16), NP (NH=2), CPL (CH=0, CD=0). Request P with len=8.
  - Required response: `vc_active_o[0]` = 1 the cycle after the last strobe. Request is granted. cc_ph = 1, cc_pd = 2.
- Exhaustion:
  - Stimulus: PH=4. Send 4 P requests with len=0, then a 5th.
  - Required response: the 5th request sees ready = 0.
  - Follow-up: strobe PH=5; the 5th request is granted one cycle later.
- Wrap-around:
  - Stimulus: preload CC so that cc_pd = 4094, with PD limit = 2. Request len=16 (need 4).
  - Required response: granted. cc_pd becomes 2. A further len=4 request stalls.
- Infinite CPL:
  - Stimulus: CH=CD=0 during `INIT`. Issue 5000 CPL grants with len=32.
  - Required response: ready stays 1 throughout. cc_cd wraps correctly to (5000×8) mod 4096 = 3136.
- Illegal request and link drop:
  - Stimulus: type=3 request.
  - Required response: ready = 0 and one `req_err_o` pulse.
  - Stimulus: with VC1 active, drop `link_active_i`.
  - Required response: ready = 0 that cycle. Next cycle `vc_active_o` = 0 and all cc = 0.
- Simultaneous events:
  - Stimulus: exhaust PH at 3, i.e. cc_ph = 3 with PH limit = 3. Strobe PH=4 together with a P request in the same cycle.
  - Required response: no grant that cycle. Grant the following cycle.
